step_rate_gen: RTL and testbench

Multi-channel step-pulse rate generator for the stepper front end. Each channel's output step rate is clk rate × rate / dividend, using a phase accumulator with carry-safe arithmetic. Each channel produces clean full-cycle step pulses of fixed width, a direction output and a signed position count. Per-channel rate and direction are loaded through a write port; all channels share one dividend.

---
 rtl/step_rate_gen.sv | 207 ++++++++++++++++++++
 tb/tb_step_rate_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/step_rate_gen.sv
// Multi-channel step-pulse rate generator: each channel steps at clk * rate / dividend via a phase accumulator.
// Latency: an accumulator event at edge k raises step at edge k; position moves at that same edge.
// Backpressure: at most one step is held pending during a pulse/gap; a further event sets sticky overrun.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_en/wr_chan/wr_rate/wr_dir   shadow rate/direction load for one channel (out-of-range index ignored)
//   dividend               shared divisor for all channels
//   enable, ovr_clr        per-channel run enable and overrun clear
//   step, dir, position, overrun   per-channel outputs (position channel i at [i*POS_BITS +: POS_BITS])
module step_rate_gen #(
    parameter int CHANNELS     = 4,
    parameter int COUNT_BITS   = 32,
    parameter int POS_BITS     = 32,
    parameter int PULSE_CYCLES = 4,
    parameter int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [CH_BITS-1:0]           wr_chan,
    input  logic [COUNT_BITS-1:0]        wr_rate,
    input  logic                         wr_dir,
    input  logic [COUNT_BITS-1:0]        dividend,
    input  logic [CHANNELS-1:0]          enable,
    input  logic [CHANNELS-1:0]          ovr_clr,
    output logic [CHANNELS-1:0]          step,
    output logic [CHANNELS-1:0]          dir,
    output logic [CHANNELS*POS_BITS-1:0] position,
    output logic [CHANNELS-1:0]          overrun
);

    localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                r_state     [CHANNELS];
    state_t                w_state_nxt [CHANNELS];
    logic [COUNT_BITS-1:0] r_acc       [CHANNELS];
    logic [COUNT_BITS-1:0] w_acc_nxt   [CHANNELS];
    logic [COUNT_BITS-1:0] r_rate      [CHANNELS];
    logic [CNT_W-1:0]      r_cnt       [CHANNELS];
    logic [CNT_W-1:0]      w_cnt_nxt   [CHANNELS];
    logic [POS_BITS-1:0]   r_pos       [CHANNELS];
    logic [POS_BITS-1:0]   w_pos_nxt   [CHANNELS];

    logic [CHANNELS-1:0]   r_dir_sh;
    logic [CHANNELS-1:0]   r_step;
    logic [CHANNELS-1:0]   w_step_nxt;
    logic [CHANNELS-1:0]   r_dir;
    logic [CHANNELS-1:0]   w_dir_nxt;
    logic [CHANNELS-1:0]   r_pend;
    logic [CHANNELS-1:0]   w_pend_nxt;
    logic [CHANNELS-1:0]   r_ovr;
    logic [CHANNELS-1:0]   w_ovr_nxt;

    // Next-state / output logic for every channel.
    always_comb begin
        logic [COUNT_BITS:0] w_sum;
        logic [COUNT_BITS:0] w_diff;
        logic                w_ev;
        logic                w_pend_eff;
        logic                w_fire;
        logic                w_ovr_set;

        w_sum      = '0;
        w_diff     = '0;
        w_ev       = 1'b0;
        w_pend_eff = 1'b0;
        w_fire     = 1'b0;
        w_ovr_set  = 1'b0;
        w_step_nxt = r_step;
        w_dir_nxt  = r_dir;
        w_pend_nxt = r_pend;
        w_ovr_nxt  = r_ovr;

        for (int i = 0; i < CHANNELS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_pos_nxt[i]   = r_pos[i];
            w_acc_nxt[i]   = r_acc[i];
            w_fire         = 1'b0;
            w_ovr_set      = 1'b0;

            // One extra bit keeps the sum exact: the compare never sees a wrapped value.
            w_sum  = {1'b0, r_acc[i]} + {1'b0, r_rate[i]};
            w_diff = w_sum - {1'b0, dividend};
            w_ev   = enable[i] && (r_rate[i] != '0) && (dividend != '0) &&
                     (w_sum >= {1'b0, dividend});
            // A pending step is discarded while the channel is disabled.
            w_pend_eff    = r_pend[i] & enable[i];
            w_pend_nxt[i] = w_pend_eff;

            if (!enable[i]) begin
                w_acc_nxt[i] = '0;
            end else if ((r_rate[i] != '0) && (dividend != '0)) begin
                if (w_ev) begin
                    // Residue only exceeds the width when rate or a stale acc outruns the
                    // dividend; those steps are lost anyway, so hold at full scale.
                    w_acc_nxt[i] = w_diff[COUNT_BITS] ? '1 : w_diff[COUNT_BITS-1:0];
                end else begin
                    w_acc_nxt[i] = w_sum[COUNT_BITS-1:0];
                end
            end

            case (r_state[i])
                S_IDLE: begin
                    if (w_ev || w_pend_eff) begin
                        w_fire = 1'b1;
                    end else begin
                        // Direction only changes with the engine quiet.
                        w_dir_nxt[i] = r_dir_sh[i];
                    end
                end
                S_HIGH: begin
                    if (r_cnt[i] == '0) begin
                        w_state_nxt[i] = S_GAP;
                        w_step_nxt[i]  = 1'b0;
                        w_cnt_nxt[i]   = CNT_LOAD;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                    end
                    if (w_ev) begin
                        if (w_pend_eff) w_ovr_set     = 1'b1;
                        else            w_pend_nxt[i] = 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt[i] != '0) begin
                        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                        if (w_ev) begin
                            if (w_pend_eff) w_ovr_set     = 1'b1;
                            else            w_pend_nxt[i] = 1'b1;
                        end
                    end else if (w_ev || w_pend_eff) begin
                        // Last gap cycle: restart straight away so the period is 2*PULSE_CYCLES.
                        w_fire = 1'b1;
                    end else begin
                        w_state_nxt[i] = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                end
            endcase

            if (w_fire) begin
                w_state_nxt[i] = S_HIGH;
                w_step_nxt[i]  = 1'b1;
                w_cnt_nxt[i]   = CNT_LOAD;
                w_pos_nxt[i]   = r_dir[i] ? r_pos[i] + POS_BITS'(1) : r_pos[i] - POS_BITS'(1);
                // Consuming a pending step while a new event arrives leaves one pending.
                w_pend_nxt[i]  = w_pend_eff & w_ev;
            end

            if (w_ovr_set)       w_ovr_nxt[i] = 1'b1;
            else if (ovr_clr[i]) w_ovr_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= S_IDLE;
                r_acc[i]   <= '0;
                r_rate[i]  <= '0;
                r_cnt[i]   <= '0;
                r_pos[i]   <= '0;
            end
            r_dir_sh <= '0;
            r_step   <= '0;
            r_dir    <= '0;
            r_pend   <= '0;
            r_ovr    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_acc[i]   <= w_acc_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_pos[i]   <= w_pos_nxt[i];
                // Out-of-range channel indices never match and are dropped.
                if (wr_en && (int'(wr_chan) == i)) begin
                    r_rate[i]   <= wr_rate;
                    r_dir_sh[i] <= wr_dir;
                end
            end
            r_step <= w_step_nxt;
            r_dir  <= w_dir_nxt;
            r_pend <= w_pend_nxt;
            r_ovr  <= w_ovr_nxt;
        end
    end

    assign step    = r_step;
    assign dir     = r_dir;
    assign overrun = r_ovr;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pos
        assign position[g*POS_BITS +: POS_BITS] = r_pos[g];
    end

endmodule

// File: tb/tb_step_rate_gen.sv
module tb_step_rate_gen;

    localparam int NCH = 3;
    localparam int CB  = 32;
    localparam int PB  = 16;
    localparam int PC  = 2;
    localparam longint unsigned MAXC = 64'hFFFF_FFFF;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [1:0]      wr_chan;
    logic [CB-1:0]   wr_rate;
    logic            wr_dir;
    logic [CB-1:0]   dividend;
    logic [NCH-1:0]  enable;
    logic [NCH-1:0]  ovr_clr;
    logic [NCH-1:0]  step;
    logic [NCH-1:0]  dir;
    logic [NCH*PB-1:0] position;
    logic [NCH-1:0]  overrun;

    step_rate_gen #(
        .CHANNELS    (NCH),
        .COUNT_BITS  (CB),
        .POS_BITS    (PB),
        .PULSE_CYCLES(PC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_chan (wr_chan),
        .wr_rate (wr_rate),
        .wr_dir  (wr_dir),
        .dividend(dividend),
        .enable  (enable),
        .ovr_clr (ovr_clr),
        .step    (step),
        .dir     (dir),
        .position(position),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time-based view of the pulse train (time of last step start)
    // plus plain integer accumulator arithmetic.
    longint unsigned m_acc  [NCH];
    longint unsigned m_rate [NCH];
    bit              m_dsh  [NCH];
    bit              m_dir  [NCH];
    bit              m_pend [NCH];
    bit              m_ovr  [NCH];
    int              m_last [NCH];
    logic [PB-1:0]   m_pos  [NCH];
    int              m_k;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; m_rate[c] = 0; m_dsh[c] = 0; m_dir[c] = 0;
            m_pend[c] = 0; m_ovr[c] = 0; m_last[c] = -1; m_pos[c] = '0;
        end
    endtask

    task automatic model_step();
        longint unsigned s;
        longint unsigned dv;
        bit ev, pe, ready, quiet, set_ovr;
        m_k++;
        dv = longint'(dividend);
        for (int c = 0; c < NCH; c++) begin
            ev = 0;
            set_ovr = 0;
            if (!enable[c]) begin
                m_acc[c] = 0;
                pe = 0;
            end else begin
                pe = m_pend[c];
                if (m_rate[c] != 0 && dv != 0) begin
                    s = m_acc[c] + m_rate[c];
                    if (s >= dv) begin
                        ev = 1;
                        s = s - dv;
                        if (s > MAXC) s = MAXC;
                    end
                    m_acc[c] = s;
                end
            end
            ready = (m_last[c] < 0) || (m_k - m_last[c] >= 2*PC);
            quiet = (m_last[c] < 0) || (m_k - m_last[c] > 2*PC);
            if (ready && (ev || pe)) begin
                m_last[c] = m_k;
                m_pos[c]  = m_dir[c] ? m_pos[c] + 1'b1 : m_pos[c] - 1'b1;
                m_pend[c] = pe && ev;
            end else begin
                m_pend[c] = pe;
                if (ev) begin
                    if (pe) set_ovr = 1;
                    else    m_pend[c] = 1;
                end
                if (quiet) m_dir[c] = m_dsh[c];
            end
            if (set_ovr)         m_ovr[c] = 1;
            else if (ovr_clr[c]) m_ovr[c] = 0;
        end
        if (wr_en && int'(wr_chan) < NCH) begin
            m_rate[wr_chan] = longint'(wr_rate);
            m_dsh[wr_chan]  = wr_dir;
        end
    endtask

    task automatic compare_all();
        bit exp_step;
        for (int c = 0; c < NCH; c++) begin
            exp_step = (m_last[c] >= 0) && (m_k - m_last[c] < PC);
            chk($sformatf("step%0d", c), step[c], exp_step);
            chk($sformatf("dir%0d", c), dir[c], m_dir[c]);
            chk($sformatf("pos%0d", c), position[c*PB +: PB], m_pos[c]);
            chk($sformatf("ovr%0d", c), overrun[c], m_ovr[c]);
        end
    endtask

    function automatic logic [CB-1:0] pick_rate(input longint unsigned dv);
        longint unsigned hi;
        case ($urandom % 8)
            0:       return '0;
            1:       return CB'(dv);
            2:       return CB'(dv - 1);
            3:       return CB'($urandom);
            default: begin
                hi = (dv / 4 > 0) ? dv / 4 : 1;
                return CB'($urandom_range(32'd1, 32'(hi)));
            end
        endcase
    endfunction

    logic [CB-1:0] div_tab [9];

    initial begin
        div_tab[0] = 32'd4;   div_tab[1] = 32'd10; div_tab[2] = 32'd7;
        div_tab[3] = 32'd0;   div_tab[4] = 32'd1;  div_tab[5] = 32'd100;
        div_tab[6] = 32'hFFFF_FFFF; div_tab[7] = 32'd3; div_tab[8] = 32'd50;

        rst_n = 1'b1; wr_en = 0; wr_chan = '0; wr_rate = '0; wr_dir = 0;
        dividend = '0; enable = '0; ovr_clr = '0;
        m_k = 0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compare_all();          // reset state
        rst_n = 1'b1;

        for (int seg = 0; seg < 9; seg++) begin
            dividend = div_tab[seg];
            enable   = '1;
            for (int cyc = 0; cyc < 250; cyc++) begin
                compare_all();
                wr_en   = ($urandom % 5 == 0) || (cyc < 3);
                wr_chan = (cyc < 3) ? 2'(cyc) : 2'($urandom % 4);
                wr_rate = (dividend == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : pick_rate(longint'(dividend));
                wr_dir  = 1'($urandom % 2);
                if ($urandom % 40 == 0) enable = enable ^ NCH'(1 << ($urandom % NCH));
                for (int c = 0; c < NCH; c++) ovr_clr[c] = ($urandom % 8 == 0);
                @(posedge clk);
                model_step();
                if ((seg == 4 || seg == 8) && cyc == 120) begin
                    // Asynchronous reset mid-run: outputs must clear before the next edge.
                    #2 rst_n = 1'b0;
                    #1;
                    model_reset();
                    compare_all();
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        compare_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
